// File: rtl/ssd_pkg.sv
// Shared constants, FSM state type and helper functions for the multiplexed
// seven-segment display driver.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } ssd_state_t;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] nib2seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/ssd_mux_display_if.sv
// Value/handshake bundle between the debug value mux and the display driver.
interface ssd_mux_display_if #(
    parameter int VAL_W = 13
);
    logic [VAL_W-1:0] value_in;
    logic             load;
    logic             hex_mode;
    logic             blank_lz;
    logic             busy;

    modport master (output value_in, load, hex_mode, blank_lz, input busy);
    modport slave  (input value_in, load, hex_mode, blank_lz, output busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter: one input bit per cycle,
// MSB first, finishing VAL_W cycles after start.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int VAL_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [VAL_W-1:0]      bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int DISP_W = 4 * DIGITS;
    localparam int CNT_W  = $clog2(VAL_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic [VAL_W-1:0]  sh;
    logic [DISP_W-1:0] adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)             cnt <= '0;
        else if (start)       cnt <= CNT_W'(VAL_W);
        else if (cnt != '0)   cnt <= cnt - 1'b1;
    end

    // Bits pushed out of the top are dropped; the caller flags overflow itself
    always_ff @(posedge clk) begin
        if (start) begin
            sh  <= bin;
            bcd <= '0;
        end else if (cnt != '0) begin
            bcd <= DISP_W'({adj, sh[VAL_W-1]});
            sh  <= sh << 1;
        end
    end

    // High during the final shift cycle
    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/ssd_mux_display.sv
// Multiplexed common-anode seven-segment driver with hex/decimal modes,
// leading-zero blanking and overflow dashes.
module ssd_mux_display
    import ssd_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int VAL_W       = 13,
    parameter int DIGIT_TICKS = 100000
) (
    input  logic                fastclk,
    input  logic                rst,
    ssd_mux_display_if.slave    bus,
    output logic [6:0]          ssd_out,
    output logic [DIGITS-1:0]   Anodes
);
    localparam int          DISP_W  = 4 * DIGITS;
    localparam int          CNT_W   = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
    localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [63:0] MAX_DEC = pow10(DIGITS) - 64'd1;

    ssd_state_t        state, state_nxt;
    logic              accept, conv_start, commit;
    logic              conv_done;
    logic [DISP_W-1:0] bcd;
    logic              hex_ovf_in, dec_ovf_in;
    logic [DISP_W-1:0] hex_q;
    logic              hex_mode_q, ovf_pend;
    logic [DISP_W-1:0] disp;
    logic              ovf;
    logic [CNT_W-1:0]  tick;
    logic [IDX_W-1:0]  idx;
    logic              zero_above;
    logic [6:0]        seg_nxt, seg_p1;
    logic [DIGITS-1:0] an_nxt, an_p1;

    bin2bcd_seq #(.VAL_W(VAL_W), .DIGITS(DIGITS)) u_conv (
        .clk   (fastclk),
        .rst   (rst),
        .start (conv_start),
        .bin   (bus.value_in),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // Stage p0: handshake FSM, capture and display register
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        conv_start = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    accept = 1'b1;
                    if (bus.hex_mode) begin
                        state_nxt = ST_COMMIT;
                    end else begin
                        state_nxt  = ST_CONV;
                        conv_start = 1'b1;
                    end
                end
            end
            ST_CONV:   if (conv_done) state_nxt = ST_COMMIT;
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy   = (state != ST_IDLE);
    assign hex_ovf_in = ((64'(bus.value_in) >> DISP_W) != 64'd0);
    assign dec_ovf_in = (64'(bus.value_in) > MAX_DEC);

    always_ff @(posedge fastclk) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge fastclk) begin
        if (accept) begin
            hex_q      <= DISP_W'(bus.value_in);
            hex_mode_q <= bus.hex_mode;
            ovf_pend   <= bus.hex_mode ? hex_ovf_in : dec_ovf_in;
        end
    end

    always_ff @(posedge fastclk) begin
        if (!rst) begin
            disp <= '0;
            ovf  <= 1'b0;
        end else if (commit) begin
            disp <= hex_mode_q ? hex_q : bcd;
            ovf  <= ovf_pend;
        end
    end

    always_ff @(posedge fastclk) begin
        if (!rst) begin
            tick <= '0;
            idx  <= '0;
        end else if (tick == CNT_W'(DIGIT_TICKS - 1)) begin
            tick <= '0;
            idx  <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    // Walk digits from the top so zero_above covers nibbles i..DIGITS-1
    always_comb begin
        seg_nxt    = SEG_BLANK;
        an_nxt     = '1;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp[4*i +: 4] == 4'd0);
            if (idx == IDX_W'(i)) begin
                an_nxt[i] = 1'b0;
                if (ovf)                                     seg_nxt = SEG_DASH;
                else if (bus.blank_lz && zero_above && i != 0) seg_nxt = SEG_BLANK;
                else                                         seg_nxt = nib2seg(disp[4*i +: 4]);
            end
        end
    end

    // Stage p1: registered pin drivers
    always_ff @(posedge fastclk) begin
        if (!rst) begin
            seg_p1 <= SEG_BLANK;
            an_p1  <= '1;
        end else begin
            seg_p1 <= seg_nxt;
            an_p1  <= an_nxt;
        end
    end

    assign ssd_out = seg_p1;
    assign Anodes  = an_p1;

endmodule

// File: tb/tb_ssd_mux_display.sv
// Bench for ssd_mux_display: three instances (4/13, 4/14, 3/14 digits/bits)
// share stimulus and are compared against an arithmetic display model.
module tb_ssd_mux_display;
    localparam int TICKS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] val_drv;
    logic        load_drv, hex_drv, blank_drv;

    always #5 clk = ~clk;

    ssd_mux_display_if #(.VAL_W(13)) if0 ();
    ssd_mux_display_if #(.VAL_W(14)) if1 ();
    ssd_mux_display_if #(.VAL_W(14)) if2 ();

    assign if0.value_in = val_drv[12:0];
    assign if1.value_in = val_drv;
    assign if2.value_in = val_drv;
    assign if0.load = load_drv;  assign if1.load = load_drv;  assign if2.load = load_drv;
    assign if0.hex_mode = hex_drv; assign if1.hex_mode = hex_drv; assign if2.hex_mode = hex_drv;
    assign if0.blank_lz = blank_drv; assign if1.blank_lz = blank_drv; assign if2.blank_lz = blank_drv;

    logic [6:0] seg0, seg1, seg2;
    logic [3:0] an0, an1;
    logic [2:0] an2;

    ssd_mux_display #(.DIGITS(4), .VAL_W(13), .DIGIT_TICKS(TICKS)) u0 (
        .fastclk(clk), .rst(rst), .bus(if0.slave), .ssd_out(seg0), .Anodes(an0));
    ssd_mux_display #(.DIGITS(4), .VAL_W(14), .DIGIT_TICKS(TICKS)) u1 (
        .fastclk(clk), .rst(rst), .bus(if1.slave), .ssd_out(seg1), .Anodes(an1));
    ssd_mux_display #(.DIGITS(3), .VAL_W(14), .DIGIT_TICKS(TICKS)) u2 (
        .fastclk(clk), .rst(rst), .bus(if2.slave), .ssd_out(seg2), .Anodes(an2));

    logic [7:0] an_a   [3];
    logic [6:0] seg_a  [3];
    logic       busy_a [3];

    always_comb begin
        an_a[0] = {4'hF, an0};
        an_a[1] = {4'hF, an1};
        an_a[2] = {5'h1F, an2};
        seg_a[0] = seg0; seg_a[1] = seg1; seg_a[2] = seg2;
        busy_a[0] = if0.busy; busy_a[1] = if1.busy; busy_a[2] = if2.busy;
    end

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] segtbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    longint unsigned exp_val [3];
    bit              exp_hex [3];

    function automatic int dig(input int k);
        return (k == 2) ? 3 : 4;
    endfunction

    function automatic int vw(input int k);
        return (k == 0) ? 13 : 14;
    endfunction

    function automatic longint unsigned p10(input int n);
        longint unsigned r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    // What slot s of instance k should show, from the value's arithmetic
    function automatic logic [6:0] exp_seg(input int k, input int s);
        longint unsigned v = exp_val[k];
        int d = dig(k);
        bit ov, zero_up;
        int digit;
        if (exp_hex[k]) begin
            ov      = (v >> (4 * d)) != 0;
            digit   = int'((v >> (4 * s)) & 15);
            zero_up = (v >> (4 * s)) == 0;
        end else begin
            ov      = v > p10(d) - 1;
            digit   = int'((v / p10(s)) % 10);
            zero_up = v < p10(s);
        end
        if (ov) return 7'b0111111;
        if (blank_drv && s > 0 && zero_up) return 7'h7F;
        return segtbl[digit];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Watch two full refresh rounds and compare every slot with the model
    task automatic check_display(input int k, input string tag);
        int d, prev, run, slot, zeros, bad_an, bad_seq, bad_stab;
        bit first_run;
        logic [6:0] got [8];
        bit seen [8];
        d = dig(k); prev = -1; run = 0; first_run = 1;
        bad_an = 0; bad_seq = 0; bad_stab = 0;
        for (int i = 0; i < 8; i++) begin seen[i] = 0; got[i] = 7'h7F; end
        for (int c = 0; c < 2 * d * TICKS + 2; c++) begin
            @(negedge clk);
            zeros = 0; slot = 0;
            for (int b = 0; b < d; b++) if (an_a[k][b] !== 1'b1) begin zeros++; slot = b; end
            if (zeros != 1) begin
                bad_an++;
            end else begin
                if (slot != prev) begin
                    if (prev >= 0) begin
                        if (slot != (prev + 1) % d) bad_seq++;
                        if (!first_run && run != TICKS) bad_seq++;
                        first_run = 0;
                    end
                    prev = slot; run = 1;
                end else begin
                    run++;
                end
                if (seen[slot] && got[slot] !== seg_a[k]) bad_stab++;
                seen[slot] = 1; got[slot] = seg_a[k];
            end
        end
        chk($sformatf("%s_u%0d_anode_onehot", tag, k), 64'(bad_an), 64'd0);
        chk($sformatf("%s_u%0d_refresh_order", tag, k), 64'(bad_seq), 64'd0);
        chk($sformatf("%s_u%0d_seg_stable", tag, k), 64'(bad_stab), 64'd0);
        for (int s = 0; s < d; s++) begin
            chk($sformatf("%s_u%0d_slot%0d_seen", tag, k, s), 64'(seen[s]), 64'd1);
            chk($sformatf("%s_u%0d_slot%0d_seg", tag, k, s), 64'(got[s]), 64'(exp_seg(k, s)));
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) check_display(k, tag);
    endtask

    task automatic do_load(input string tag, input logic [13:0] v, input logic hx,
                           input int second_at, input logic [13:0] v2);
        int bc [3];
        @(negedge clk);
        val_drv = v; hex_drv = hx; load_drv = 1'b1;
        @(negedge clk);
        load_drv = 1'b0;
        for (int k = 0; k < 3; k++) bc[k] = 0;
        for (int c = 0; c < 40; c++) begin
            for (int k = 0; k < 3; k++) if (busy_a[k] === 1'b1) bc[k]++;
            if (second_at > 0 && c == second_at) begin
                val_drv = v2; load_drv = 1'b1;
            end else begin
                load_drv = 1'b0;
            end
            @(negedge clk);
        end
        load_drv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_u%0d_busy_cycles", tag, k), 64'(bc[k]),
                64'(hx ? 1 : vw(k) + 1));
            chk($sformatf("%s_u%0d_idle_after", tag, k), 64'(busy_a[k]), 64'd0);
            exp_val[k] = longint'(v) & ((longint'(1) << vw(k)) - 1);
            exp_hex[k] = hx;
        end
        check_all(tag);
    endtask

    initial begin
        rst = 1'b0; load_drv = 1'b1; val_drv = 14'd1234; hex_drv = 1'b0; blank_drv = 1'b0;
        for (int k = 0; k < 3; k++) begin exp_val[k] = 0; exp_hex[k] = 0; end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_u%0d_anodes", k), 64'(an_a[k]), 64'hFF);
            chk($sformatf("rst_u%0d_seg", k), 64'(seg_a[k]), 64'h7F);
            chk($sformatf("rst_u%0d_busy", k), 64'(busy_a[k]), 64'd0);
        end
        load_drv = 1'b0; rst = 1'b1;
        check_all("after_rst");

        do_load("dec1234", 14'd1234, 1'b0, 0, 14'd0);
        do_load("hex1ABC", 14'h1ABC, 1'b1, 0, 14'd0);

        blank_drv = 1'b1;
        do_load("blank7", 14'd7, 1'b0, 0, 14'd0);
        blank_drv = 1'b0;
        check_all("blank_live_off");
        blank_drv = 1'b1;
        do_load("blank0", 14'd0, 1'b0, 0, 14'd0);
        do_load("blank_hex", 14'h00A0, 1'b1, 0, 14'd0);
        blank_drv = 1'b0;

        do_load("ovf12000", 14'd12000, 1'b0, 0, 14'd0);
        do_load("clear5", 14'd5, 1'b0, 0, 14'd0);
        do_load("hex_ovf", 14'h3FFF, 1'b1, 0, 14'd0);
        do_load("dec999", 14'd999, 1'b0, 0, 14'd0);

        do_load("ignored", 14'd9999, 1'b0, 3, 14'd1111);

        // Reset in the middle of a decimal conversion
        @(negedge clk);
        val_drv = 14'd4321; hex_drv = 1'b0; load_drv = 1'b1;
        @(negedge clk);
        load_drv = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("midrst_u%0d_busy", k), 64'(busy_a[k]), 64'd0);
            chk($sformatf("midrst_u%0d_anodes", k), 64'(an_a[k]), 64'hFF);
            exp_val[k] = 0; exp_hex[k] = 0;
        end
        rst = 1'b1;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk($sformatf("midrst_u%0d_stays_idle", k), 64'(busy_a[k]), 64'd0);
        check_all("midrst");

        for (int r = 0; r < 10; r++) begin
            blank_drv = 1'($urandom_range(0, 1));
            do_load($sformatf("rnd%0d", r), 14'($urandom_range(0, 16383)),
                    1'($urandom_range(0, 1)), 0, 14'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ssd_mux_display.md
Name: ssd_mux_display

Overview:
Parametrised successor to the fixed 4-digit seven-segment driver. Displays a VAL_W-bit binary value on DIGITS multiplexed common-anode digits, in either hex or decimal mode. Decimal conversion uses a sequential shift-add-3 (double-dabble) converter with a load/busy handshake. Adds leading-zero blanking and an overflow indication. Sits between the processor's debug value mux and the board's SSD pins, clocked by fastclk.

Parameters:
DIGITS, 4, number of digits (anodes); 1..8
VAL_W, 13, width of value_in
DIGIT_TICKS, 100000, fastclk cycles each digit stays lit; >=2

Ports:
fastclk  in  1  sole clock
rst  in  1  synchronous reset, active-low (asserted when 0, sampled on fastclk rising edge)
value_in  in  VAL_W  value to display, sampled on accepted load
load  in  1  request to capture value_in/hex_mode
hex_mode  in  1  1 = hex digits, 0 = decimal
blank_lz  in  1  1 = blank leading zero digits (level, applied live)
busy  out  1  conversion in progress; load ignored while high
ssd_out  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}
Anodes  out  DIGITS  digit enables, active-low, one-hot-low

Behaviour:
- Reset (rst=0 at edge): Anodes all 1, ssd_out 7'h7F, busy 0, display register all-zero nibbles, overflow flag 0, digit index 0, refresh counter 0, FSM IDLE. Reset mid-conversion aborts it; the display register is cleared.
- FSM states: IDLE, CONV, COMMIT.
- IDLE, load=1: capture value_in and hex_mode.
  - Hex mode: go to COMMIT next cycle.
  - Decimal mode: go to CONV, clear the BCD register, set busy.
- CONV: runs exactly VAL_W cycles. Each cycle, add 3 to every BCD nibble >= 5, then shift left by one bit, bringing in the value MSB first. Then go to COMMIT.
- COMMIT: one cycle. Write the display register atomically, drop busy, return to IDLE.
- busy timing:
  - Decimal: busy=1 from the cycle after load through the COMMIT cycle (VAL_W+1 cycles). The display register changes VAL_W+2 edges after the load edge.
  - Hex: busy=1 for the single COMMIT cycle. The display register changes 2 edges after the load edge.
- load while busy=1: ignored, no queueing.
- Overflow, evaluated at capture and applied at COMMIT:
  - Decimal: overflow if value > 10^DIGITS-1.
  - Hex: overflow if any value bit at index >= 4*DIGITS is set.
  - On overflow every digit shows a dash (7'b0111111). The flag is cleared by the next non-overflow commit.
- Hex display: nibble i = value[4i+3:4i]; missing upper bits read as zero.
- Refresh:
  - Counter runs 0..DIGIT_TICKS-1 continuously. At terminal count it wraps to 0 and the digit index advances modulo DIGITS (DIGITS-1 wraps to 0).
  - Anodes and ssd_out are registered and follow the index with 1 cycle latency. Only Anodes[index] is 0.
- Leading-zero blanking: digit i>0 is blanked (ssd_out=7'h7F, anode still driven low in its slot) when blank_lz=1, there is no overflow, and nibbles i..DIGITS-1 are all zero. Digit 0 is never blanked.
- Segment codes {g..a}, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Widths: BCD register is 4*DIGITS bits; bits shifted out of its top are discarded (overflow is already flagged). Refresh counter is $clog2(DIGIT_TICKS) bits; index is $clog2(DIGITS) bits, minimum 1.

Decomposition:
- Package ssd_pkg: segment constants SEG_BLANK (7'h7F) and SEG_DASH; a function nibble-to-segments; FSM state typedef.
- Sub-module bin2bcd_seq: the sequential double-dabble converter. Ports: start, bin, done, bcd.
- Top level holds the handshake FSM, display register, refresh counter, and output registers.

Test Plan (DIGIT_TICKS=4 unless noted):
1. Reset: hold rst=0 for 3 cycles while load=1 -> Anodes=4'hF, ssd_out=7'h7F, busy=0. After release the display shows "0000" (blank_lz=0), e.g. slot 0 ssd_out=1000000.
2. Decimal load: value_in=1234, hex_mode=0 -> busy high for 14 cycles. Then digits 3..0 = 1,2,3,4; digit 0 slot shows Anodes=1110, ssd_out=0011001.
3. Hex load: value_in=13'h1ABC, hex_mode=1 -> busy for 1 cycle. Digits show 1,A,b,C; slot with Anodes=1011 shows ssd_out=0001000.
4. Blanking: blank_lz=1, decimal load of 7 -> slots 3..1 give ssd_out=7F with their anode low; slot 0 gives 1111000. Load of 0 -> slot 0 gives 1000000.
5. Overflow: VAL_W=14 instance, decimal load of 12000 -> all four slots give 0111111. A following load of 5 clears the dashes.
6. Handshake/reset: load 9999 then load 1111 at cycle 3 -> the second load is ignored and the display shows 9999. Separately, rst=0 at cycle 5 of a conversion -> busy=0 the next cycle and the display is all zero.
